// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_ctrl
//  Brief    : Command-driven LED pattern sequencer (COUNT / SHIFT / DIFF)
//             with a one-entry pending command slot and tick prescaler.
//  Revision : 1.0
// ============================================================================
module led_seq_ctrl #(
  parameter int LOG2DELAY = 25,
  parameter int NLED      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_mode,
  input  logic [7:0]      cmd_steps,
  output logic [NLED-1:0] led,
  output logic            diff_i,
  output logic            diff_t,
  output logic            busy,
  output logic            done
);

  // State codes equal the command mode codes, so STOP maps directly onto IDLE.
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_COUNT = 2'b01;
  localparam logic [1:0] S_SHIFT = 2'b10;
  localparam logic [1:0] S_DIFF  = 2'b11;

  localparam logic [NLED-1:0] SHIFT_SEED = {{(NLED-1){1'b0}}, 1'b1};

  logic [1:0]           state_q,  state_d;
  logic [LOG2DELAY-1:0] presc_q,  presc_d;
  logic [7:0]           steps_q,  steps_d;
  logic                 ready_q,  ready_d;
  logic [1:0]           pmode_q,  pmode_d;
  logic [7:0]           psteps_q, psteps_d;
  logic [NLED-1:0]      led_q,    led_d;
  logic                 diff_i_q, diff_i_d;
  logic                 diff_t_q, diff_t_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;

  logic tick;
  logic accept;
  logic apply;
  logic complete;
  logic advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      steps_q  <= '0;
      ready_q  <= 1'b1;
      pmode_q  <= '0;
      psteps_q <= '0;
      led_q    <= '0;
      diff_i_q <= 1'b0;
      diff_t_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      steps_q  <= steps_d;
      ready_q  <= ready_d;
      pmode_q  <= pmode_d;
      psteps_q <= psteps_d;
      led_q    <= led_d;
      diff_i_q <= diff_i_d;
      diff_t_q <= diff_t_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // A pending command is only visible once latched, so a tick on the accept
  // edge itself can never apply it.
  always_comb begin
    tick     = (state_q != S_IDLE) && (presc_q == '1);
    accept   = cmd_valid && ready_q;
    apply    = !ready_q && ((state_q == S_IDLE) || tick);
    complete = !apply && tick && (steps_q == 8'd1);
    advance  = !apply && tick && !complete;

    state_d  = state_q;
    presc_d  = presc_q;
    steps_d  = steps_q;
    ready_d  = ready_q;
    pmode_d  = pmode_q;
    psteps_d = psteps_q;

    if (apply) begin
      ready_d = 1'b1;
    end else if (accept) begin
      ready_d  = 1'b0;
      pmode_d  = cmd_mode;
      psteps_d = cmd_steps;
    end

    if (apply) begin
      state_d = pmode_q;
      presc_d = '0;
      steps_d = psteps_q;
    end else begin
      if (state_q != S_IDLE) begin
        presc_d = presc_q + 1'b1;
      end
      if (complete) begin
        state_d = S_IDLE;
        steps_d = '0;
      end else if (advance && (steps_q != 8'd0)) begin
        steps_d = steps_q - 8'd1;
      end
    end
  end

  always_comb begin
    led_d    = led_q;
    diff_i_d = diff_i_q;

    if (apply) begin
      led_d    = (pmode_q == S_SHIFT) ? SHIFT_SEED : '0;
      diff_i_d = 1'b0;
    end else if (complete) begin
      led_d    = '0;
      diff_i_d = 1'b0;
    end else if (advance) begin
      case (state_q)
        S_COUNT: led_d    = led_q + 1'b1;
        S_SHIFT: led_d    = {led_q[NLED-2:0], led_q[NLED-1]};
        S_DIFF:  diff_i_d = ~diff_i_q;
        default: led_d    = led_q;
      endcase
    end

    diff_t_d = (state_d != S_DIFF);
    busy_d   = (state_d != S_IDLE);
    done_d   = complete;
  end

  assign cmd_ready = ready_q;
  assign led       = led_q;
  assign diff_i    = diff_i_q;
  assign diff_t    = diff_t_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire
